dct_da_accumulator: RTL and testbench
=====================================

// Module: dct_da_accumulator
// PURPOSE
// Bit-serial distributed-arithmetic (DA) engine for one DCT output coefficient.
// - Takes four two's-complement samples and walks their bit planes, LSB first.
// - Drives the 3-bit address and chip-select of the 8-entry offset-binary coefficient ROM.
// - Shift-accumulates the returned 16-bit Q2.14 partial sums into y = c*(x0+x1+x2+x3) form.
// - Sits directly downstream of that ROM; its result feeds the DCT output/quantiser stage.
// PARAMETERS
// SAMPLE_W  8        sample width, bit planes per conversion (N)
// ROM_W     16       ROM data width, signed Q2.14
// FRAC_EXT  8        extra LSBs below ROM LSB kept in accumulator
// ACC_W     26       accumulator/result width, signed, LSB = 2^-(14+FRAC_EXT)
// OFFSET    -46342   offset-binary correction constant in ACC_W units (zero input -> zero output)
// OUT_W     16       y_out width when DA_ROUND_EN is defined
// PORTS
// clk       in   1        clock, rising edge
// rst       in   1        synchronous reset, active-high
// in_valid  in   1        sample set valid
// in_ready  out  1        block can accept a sample set
// x_in      in   4*SAMPLE_W  {x3,x2,x1,x0}, x0 in LSBs, signed fractions
// rom_addr  out  3        ROM address
// rom_cs    out  1        ROM chip select
// rom_data  in   ROM_W    ROM data, combinational, same cycle as rom_addr
// out_valid out  1        result valid
// out_ready in   1        consumer accepts result
// y_out     out  ACC_W (OUT_W if DA_ROUND_EN)  coefficient result
// BEHAVIOUR
// - Reset: state IDLE, in_ready=1, out_valid=0, rom_cs=0, rom_addr=0, y_out=0, acc=0, bit_cnt=0.
// - FSM: IDLE -> (in_valid&in_ready) latch x_in, acc=0, bit_cnt=0 -> SHIFT.
//   SHIFT: bit plane n = bit_cnt (0..N-2 covers x bits 0..N-2), N-1 cycles -> SIGN.
//   SIGN: plane n=N-1 (sign bits), 1 cycle -> DONE.  DONE: out_valid=1 until out_ready -> IDLE.
// - in_ready=1 only in IDLE; x_in ignored elsewhere. rom_cs=1 only in SHIFT/SIGN (exactly N cycles).
// - Address fold per plane: b_k = bit n of x_k; rom_addr = {b1,b2,b3} ^ {3{b0}}; Q = b0 ? -rom_data : rom_data.
// - Arithmetic: Qe = sign-extend(Q) << FRAC_EXT to ACC_W.
//   SHIFT: acc <= (acc + Qe) >>> 1 (arithmetic).  SIGN: result = acc - Qe + OFFSET, registered to y_out.
// - No saturation; ACC_W sized so |y| < 4 cannot overflow. Negating 0x8000 not reachable (ROM range).
// - Latency: accept edge to out_valid = N+1 cycles; throughput one set per N+2 cycles minimum.
// - y_out holds value while out_valid=1 and out_ready=0; y_out stable in IDLE until next result.
// - out_valid&out_ready in DONE: return to IDLE, in_ready=1 next cycle (no same-cycle accept).
// - rst in any state: immediate return to reset values next edge; partial result discarded.
// CONFIGURATION
// DCT_DA_ROUND_EN defined: y_out is OUT_W bits, result rounded half-up from ACC_W by adding
//   2^(ACC_W-OUT_W-1) then dropping ACC_W-OUT_W LSBs, registered in the SIGN cycle; latency unchanged.
// Not defined: y_out is full ACC_W result, no rounding logic present.
// STRUCTURE
// - Package dct_da_pkg: SAMPLE_W/ROM_W/FRAC_EXT/ACC_W defaults, OFFSET constant, state enum
//   (ST_IDLE, ST_SHIFT, ST_SIGN, ST_DONE), ROM constants C4_P=16'h2D41, C4_N=16'hD2BE, C4X2_N=16'hA57D.
// - One sub-module: dct_da_addr_fold (combinational plane-select, XOR fold, negate flag).
// - ROM is external; this block never instantiates it.
// TESTING
// - x_in all 0 -> rom_addr=000 and rom_cs=1 for exactly 8 cycles, y_out=0, out_valid at cycle 9.
// - x0..x3=8'h40 (0.5) -> y_out = bit-true model value, approx 1.4142*2^22 (within 1 ROM LSB=256).
// - x0=8'h80, others 0 -> plane 7 addr=111 negated; y_out approx -0.7071*2^22 per bit-true model.
// - Hold out_ready=0 for 5 cycles in DONE -> out_valid, y_out stable; in_valid ignored, in_ready=0.
// - rst asserted at SHIFT cycle 3 -> next cycle IDLE, rom_cs=0, out_valid=0; new set gives correct result.
// - Random 1000 sets, both macro settings -> y_out equals bit-true reference model exactly.

Source files
------------

// File: rtl/dct_da_pkg.sv
// Shared constants, state encoding and helpers for the bit-serial DA coefficient engine.
// Honours DCT_DA_ROUND_EN: when defined, the result port narrows to OUT_W with half-up rounding.
package dct_da_pkg;

  localparam int SAMPLE_W = 8;
  localparam int ROM_W    = 16;
  localparam int FRAC_EXT = 8;
  localparam int ACC_W    = 26;
  localparam int OUT_W    = 16;
  localparam int CNT_W    = $clog2(SAMPLE_W);

`ifdef DCT_DA_ROUND_EN
  localparam int Y_W      = OUT_W;
  localparam int DROP_W   = ACC_W - OUT_W;
  localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(1) <<< (DROP_W - 1);
`else
  localparam int Y_W      = ACC_W;
`endif

  // Cancels the offset-binary bias so an all-zero sample set yields exactly zero.
  localparam logic signed [ACC_W-1:0] OFFSET = ACC_W'(-46342);

  localparam logic [ROM_W-1:0] C4_P   = 16'h2D41;
  localparam logic [ROM_W-1:0] C4_N   = 16'hD2BE;
  localparam logic [ROM_W-1:0] C4X2_N = 16'hA57D;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_SIGN,
    ST_DONE
  } state_t;

  function automatic logic signed [ACC_W-1:0] extend_q(input logic signed [ROM_W-1:0] q);
    logic signed [ACC_W-1:0] qx;
    qx = ACC_W'(q);
    return qx <<< FRAC_EXT;
  endfunction

endpackage

// File: rtl/dct_da_accumulator_if.sv
// Sample handshake, ROM port and result handshake of the DA coefficient engine.
// Result width follows DCT_DA_ROUND_EN through dct_da_pkg::Y_W.
interface dct_da_accumulator_if;
  import dct_da_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [4*SAMPLE_W-1:0]   x_in;
  logic [2:0]              rom_addr;
  logic                    rom_cs;
  logic [ROM_W-1:0]        rom_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [Y_W-1:0]          y_out;

  modport master (
    output in_valid, x_in, rom_data, out_ready,
    input  in_ready, rom_addr, rom_cs, out_valid, y_out
  );

  modport slave (
    input  in_valid, x_in, rom_data, out_ready,
    output in_ready, rom_addr, rom_cs, out_valid, y_out
  );

endinterface

// File: rtl/dct_da_addr_fold.sv
// Selects one bit plane of the four latched samples and folds it onto the half-size ROM.
module dct_da_addr_fold
  import dct_da_pkg::*;
(
  input  logic [4*SAMPLE_W-1:0] x_set,
  input  logic [CNT_W-1:0]      plane,
  output logic [2:0]            addr,
  output logic                  neg
);

  logic [3:0] plane_bits;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_plane
      logic [SAMPLE_W-1:0] sample;
      assign sample         = x_set[gi*SAMPLE_W +: SAMPLE_W];
      assign plane_bits[gi] = sample[plane];
    end
  endgenerate

  // x0's bit picks the mirrored half: invert the other bits and negate the ROM word.
  assign addr = {plane_bits[1], plane_bits[2], plane_bits[3]} ^ {3{plane_bits[0]}};
  assign neg  = plane_bits[0];

endmodule

// File: rtl/dct_da_accumulator.sv
// Bit-serial DA engine: walks sample bit planes LSB first and shift-accumulates ROM partial sums.
// DCT_DA_ROUND_EN selects a rounded OUT_W result instead of the full ACC_W accumulator value.
module dct_da_accumulator
  import dct_da_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  dct_da_accumulator_if.slave bus
);

  state_t                   state_reg, state_next;
  logic [4*SAMPLE_W-1:0]    x_reg;
  logic [CNT_W-1:0]         bit_cnt_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic [Y_W-1:0]           y_reg;

  logic [2:0]               fold_addr;
  logic                     fold_neg;
  logic                     rom_cs;
  logic signed [ROM_W-1:0]  rom_q;
  logic signed [ACC_W-1:0]  rom_qe;
  logic signed [ACC_W-1:0]  result;
  logic [Y_W-1:0]           y_next;

  dct_da_addr_fold u_fold (
    .x_set (x_reg),
    .plane (bit_cnt_reg),
    .addr  (fold_addr),
    .neg   (fold_neg)
  );

  assign rom_q  = fold_neg ? -$signed(bus.rom_data) : $signed(bus.rom_data);
  assign rom_qe = extend_q(rom_q);
  // The sign plane carries negative weight, so it is subtracted rather than shifted in.
  assign result = acc_reg - rom_qe + OFFSET;

`ifdef DCT_DA_ROUND_EN
  assign y_next = Y_W'((result + ROUND_HALF) >>> DROP_W);
`else
  assign y_next = result;
`endif

  always_comb begin
    state_next    = state_reg;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    rom_cs        = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        rom_cs = 1'b1;
        if (bit_cnt_reg == CNT_W'(SAMPLE_W - 2)) state_next = ST_SIGN;
      end
      ST_SIGN: begin
        rom_cs     = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.rom_cs   = rom_cs;
  assign bus.rom_addr = rom_cs ? fold_addr : 3'b000;
  assign bus.y_out    = y_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      x_reg       <= '0;
      bit_cnt_reg <= '0;
      acc_reg     <= '0;
      y_reg       <= '0;
    end else begin
      state_reg <= state_next;
      unique case (state_reg)
        ST_IDLE: begin
          if (bus.in_valid) begin
            x_reg       <= bus.x_in;
            bit_cnt_reg <= '0;
            acc_reg     <= '0;
          end
        end
        ST_SHIFT: begin
          acc_reg     <= (acc_reg + rom_qe) >>> 1;
          bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
        end
        ST_SIGN: y_reg <= y_next;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dct_da_accumulator.sv
// Randomized self-checking bench for dct_da_accumulator against a closed-form DA reference.
// Builds with or without DCT_DA_ROUND_EN; expectations follow the same macro.
module tb_dct_da_accumulator;
  import dct_da_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  dct_da_accumulator_if bus();

  dct_da_accumulator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Offset-binary C4 table: entry depends only on how many of the three address bits are set.
  function automatic longint rom_val(input logic [2:0] a);
    case (int'(a[0]) + int'(a[1]) + int'(a[2]))
      0:       return -23171;
      1:       return -11586;
      2:       return 0;
      default: return 11585;
    endcase
  endfunction

  always_comb bus.rom_data = 16'(rom_val(bus.rom_addr));

  // Reference in ACC_W units: plane n (n<7) weighs 2^(n+1), sign plane weighs -2^8.
  function automatic longint model(input logic [31:0] x);
    longint sum;
    sum = 0;
    for (int n = 0; n < 8; n++) begin
      logic b0, b1, b2, b3;
      logic [2:0] idx;
      longint q;
      b0 = x[n]; b1 = x[8+n]; b2 = x[16+n]; b3 = x[24+n];
      idx = b0 ? {~b1, ~b2, ~b3} : {b1, b2, b3};
      q = b0 ? -rom_val(idx) : rom_val(idx);
      if (n < 7) sum += q * (longint'(1) <<< (n + 1));
      else       sum -= q * 256;
    end
    return sum - 46342;
  endfunction

  function automatic longint exp_y(input longint r);
`ifdef DCT_DA_ROUND_EN
    return (r + (longint'(1) <<< (ACC_W - OUT_W - 1))) >>> (ACC_W - OUT_W);
`else
    return r;
`endif
  endfunction

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_set(input logic [31:0] x, input longint exp, input int hold,
                         output logic [2:0] last_addr, output int nonzero_addr);
    int     guard;
    int     cs_cnt;
    longint y;
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      step();
      guard++;
    end
    chk("in_ready_wait", longint'(bus.in_ready), 1);
    bus.x_in     = x;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.x_in     = $urandom;
    cs_cnt = 0;
    nonzero_addr = 0;
    last_addr = 3'b000;
    guard = 0;
    while (!bus.out_valid && guard < 40) begin
      if (bus.rom_cs) begin
        cs_cnt++;
        last_addr = bus.rom_addr;
        if (bus.rom_addr != 3'b000) nonzero_addr++;
      end
      if (bus.in_ready) begin
        chk("busy_in_ready", longint'(bus.in_ready), 0);
      end
      step();
      guard++;
    end
    chk("out_valid_timeout", longint'(bus.out_valid), 1);
    chk("rom_cs_cycles", cs_cnt, SAMPLE_W);
    chk("rom_cs_done", longint'(bus.rom_cs), 0);
    y = longint'($signed(bus.y_out));
    chk("y_out", y, exp);
    $display("set x=%h y=%0d exp=%0d hold=%0d", x, y, exp, hold);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.x_in     = $urandom;
      step();
      chk("hold_valid", longint'(bus.out_valid), 1);
      chk("hold_in_ready", longint'(bus.in_ready), 0);
      chk("hold_y", longint'($signed(bus.y_out)), y);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("release_valid", longint'(bus.out_valid), 0);
    chk("release_in_ready", longint'(bus.in_ready), 1);
    chk("idle_y_stable", longint'($signed(bus.y_out)), y);
  endtask

  initial begin
    logic [2:0]  last_addr;
    int          nz;
    logic [31:0] x;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x_in      = '0;

    rst = 1'b1;
    repeat (3) step();
    chk("rst_in_ready", longint'(bus.in_ready), 1);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_rom_cs", longint'(bus.rom_cs), 0);
    chk("rst_rom_addr", longint'(bus.rom_addr), 0);
    chk("rst_y_out", longint'(bus.y_out), 0);
    rst = 1'b0;
    step();

    // All-zero samples: address 000 on every plane and a zero result.
    run_set(32'h0000_0000, exp_y(0), 1, last_addr, nz);
    chk("zero_addr", nz, 0);

    // Four samples of 0.5 give roughly 1.4142 * 2^22.
    run_set(32'h4040_4040, exp_y(5931776), 0, last_addr, nz);

    // x0 = -1 alone: sign plane folds to 111, result roughly -0.7071 * 2^22.
    run_set(32'h0000_0080, exp_y(-2966016), 5, last_addr, nz);
    chk("sign_plane_addr", longint'(last_addr), 7);

    // Reset partway through SHIFT discards the conversion.
    bus.x_in     = 32'h1234_5678;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (2) step();
    chk("mid_shift_cs", longint'(bus.rom_cs), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_in_ready", longint'(bus.in_ready), 1);
    chk("midrst_rom_cs", longint'(bus.rom_cs), 0);
    chk("midrst_out_valid", longint'(bus.out_valid), 0);
    chk("midrst_rom_addr", longint'(bus.rom_addr), 0);
    chk("midrst_y_out", longint'(bus.y_out), 0);
    x = 32'h7F81_C03D;
    run_set(x, exp_y(model(x)), 2, last_addr, nz);

    for (int t = 0; t < 1000; t++) begin
      x = $urandom;
      run_set(x, exp_y(model(x)), int'($urandom_range(0, 2)), last_addr, nz);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
